// File: rtl/turbo_frame_sequencer_if.sv
// Byte-stream, encoder-control and output-stream signals of the turbo frame sequencer.
interface turbo_frame_sequencer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       enc_clr;
  logic [7:0] enc_data;
  logic       enc_start;
  logic [7:0] enc_parity;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic [7:0] byte_cnt;

  // Sequencer side
  modport master (
    input  in_data, in_valid, enc_parity, out_ready,
    output in_ready, enc_clr, enc_data, enc_start,
           out_data, out_valid, out_last, busy, byte_cnt
  );

  // Environment side: byte source, encoder and output sink
  modport slave (
    output in_data, in_valid, enc_parity, out_ready,
    input  in_ready, enc_clr, enc_data, enc_start,
           out_data, out_valid, out_last, busy, byte_cnt
  );
endinterface

// File: rtl/turbo_frame_sequencer.sv
// Frame controller for the 8-bit turbo encoder: clears the encoder per frame, fires it
// once per byte, emits systematic + parity bytes, then flushes TAIL_LEN zero bytes.
module turbo_frame_sequencer #(
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned ENC_LAT   = 1,
  parameter int unsigned TAIL_LEN  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  turbo_frame_sequencer_if.master bus
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned WAIT_W = 3;
  localparam int unsigned TAIL_W = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_ACCEPT, S_FIRE, S_WAIT, S_SEND_SYS, S_SEND_PAR, S_TAIL
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   par_q, par_d;
  logic [DATA_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [TAIL_W-1:0]   tail_cnt_q, tail_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                tail_flag_q, tail_flag_d;

  logic                in_ready_q, in_ready_d;
  logic                enc_clr_q, enc_clr_d;
  logic                enc_start_q, enc_start_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic                busy_q, busy_d;

  // State, datapath and registered-output update
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      par_q       <= '0;
      byte_cnt_q  <= '0;
      tail_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      tail_flag_q <= 1'b0;
      in_ready_q  <= 1'b0;
      enc_clr_q   <= 1'b0;
      enc_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      par_q       <= par_d;
      byte_cnt_q  <= byte_cnt_d;
      tail_cnt_q  <= tail_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      tail_flag_q <= tail_flag_d;
      in_ready_q  <= in_ready_d;
      enc_clr_q   <= enc_clr_d;
      enc_start_q <= enc_start_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and datapath; outputs are decoded from the next state so they register
  // in step with the state they belong to
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    par_d       = par_q;
    byte_cnt_d  = byte_cnt_q;
    tail_cnt_d  = tail_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    tail_flag_d = tail_flag_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) state_d = S_CLR;
      end
      S_CLR: begin
        byte_cnt_d = '0;
        tail_cnt_d = '0;
        state_d    = S_ACCEPT;
      end
      S_ACCEPT: begin
        if (bus.in_valid && in_ready_q) begin
          data_d      = bus.in_data;
          tail_flag_d = 1'b0;
          state_d     = S_FIRE;
        end
      end
      S_FIRE: begin
        wait_cnt_d = WAIT_W'(ENC_LAT - 1);
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q == '0) begin
          par_d   = bus.enc_parity;
          state_d = tail_flag_q ? S_SEND_PAR : S_SEND_SYS;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end
      S_SEND_SYS: begin
        if (bus.out_ready) state_d = S_SEND_PAR;
      end
      S_SEND_PAR: begin
        if (bus.out_ready) begin
          if (!tail_flag_q) begin
            byte_cnt_d = byte_cnt_q + DATA_W'(1);
            if ((9'(byte_cnt_q) + 9'd1) < 9'(FRAME_LEN)) state_d = S_ACCEPT;
            else if (TAIL_LEN != 0)                       state_d = S_TAIL;
            else                                          state_d = S_IDLE;
          end else begin
            tail_cnt_d = tail_cnt_q + TAIL_W'(1);
            if ((3'(tail_cnt_q) + 3'd1) < 3'(TAIL_LEN)) state_d = S_TAIL;
            else                                         state_d = S_IDLE;
          end
        end
      end
      S_TAIL: begin
        data_d      = '0;
        tail_flag_d = 1'b1;
        state_d     = S_FIRE;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_ACCEPT);
    enc_clr_d   = (state_d == S_CLR);
    enc_start_d = (state_d == S_FIRE);
    out_valid_d = (state_d == S_SEND_SYS) || (state_d == S_SEND_PAR);
    busy_d      = (state_d != S_IDLE);
    out_data_d  = '0;
    out_last_d  = 1'b0;
    if (state_d == S_SEND_SYS) out_data_d = data_d;
    if (state_d == S_SEND_PAR) begin
      out_data_d = par_d;
      if (tail_flag_d) out_last_d = (3'(tail_cnt_d) + 3'd1) >= 3'(TAIL_LEN);
      else             out_last_d = (TAIL_LEN == 0) &&
                                    ((9'(byte_cnt_d) + 9'd1) >= 9'(FRAME_LEN));
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.enc_clr   = enc_clr_q;
  assign bus.enc_data  = data_q;
  assign bus.enc_start = enc_start_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
  assign bus.byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_turbo_frame_sequencer.sv
// Bench for turbo_frame_sequencer: two instances (ENC_LAT=1/TAIL_LEN=1 and
// ENC_LAT=3/TAIL_LEN=0) share scenarios; output streams are checked against a
// frame-level model built from the bytes each instance actually accepted.
module tb_turbo_frame_sequencer;

  localparam int NDUT      = 2;
  localparam int FRAME_LEN = 4;

  typedef logic [7:0] byte_t;
  typedef byte_t      byte_q_t[$];
  typedef bit         bit_q_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   vprob = 0;
  int   rprob = 0;

  byte_t src_q [NDUT][$];
  byte_t acc_q [NDUT][$];
  byte_t obs_d [NDUT][$];
  bit    obs_l [NDUT][$];
  int    clr_cnt   [NDUT];
  int    start_cnt [NDUT];

  logic       in_valid_w [NDUT];
  logic       in_ready_w [NDUT];
  logic       enc_clr_w  [NDUT];
  logic       enc_start_w[NDUT];
  logic       out_valid_w[NDUT];
  logic       out_ready_w[NDUT];
  logic       out_last_w [NDUT];
  logic       busy_w     [NDUT];
  logic [7:0] out_data_w [NDUT];
  logic [7:0] enc_data_w [NDUT];
  logic [7:0] byte_cnt_w [NDUT];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int tail_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Frame-level model: each data byte yields itself then its inverted parity; after every
  // FRAME_LEN bytes come tail parity bytes of a zero input (FF). Last flag on frame end.
  function automatic void build_exp(input byte_q_t bytes, input int tail,
                                    output byte_q_t ed, output bit_q_t el);
    ed = {};
    el = {};
    for (int i = 0; i < bytes.size(); i++) begin
      ed.push_back(bytes[i]);
      el.push_back(1'b0);
      ed.push_back(~bytes[i]);
      el.push_back((tail == 0) && ((i % FRAME_LEN) == FRAME_LEN - 1));
      if ((i % FRAME_LEN) == FRAME_LEN - 1)
        for (int t = 0; t < tail; t++) begin
          ed.push_back(8'hFF);
          el.push_back(t == tail - 1);
        end
    end
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned ENC_LAT  = (g == 0) ? 1 : 3;
    localparam int unsigned TAIL_LEN = (g == 0) ? 1 : 0;

    turbo_frame_sequencer_if bus ();

    turbo_frame_sequencer #(
      .FRAME_LEN(FRAME_LEN),
      .ENC_LAT  (ENC_LAT),
      .TAIL_LEN (TAIL_LEN)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );

    // Encoder stub: parity = ~enc_data, valid only ENC_LAT cycles after enc_start
    byte_t pend = 8'h00;
    int    lat_cnt = 0;
    always @(posedge clk) begin
      if (bus.enc_start === 1'b1) begin
        pend    <= ~bus.enc_data;
        lat_cnt <= ENC_LAT;
      end else if (lat_cnt != 0) begin
        lat_cnt <= lat_cnt - 1;
      end
    end
    assign bus.enc_parity = (lat_cnt == 1) ? pend : 8'hEE;

    assign in_valid_w[g]  = bus.in_valid;
    assign in_ready_w[g]  = bus.in_ready;
    assign enc_clr_w[g]   = bus.enc_clr;
    assign enc_start_w[g] = bus.enc_start;
    assign out_valid_w[g] = bus.out_valid;
    assign out_ready_w[g] = bus.out_ready;
    assign out_last_w[g]  = bus.out_last;
    assign busy_w[g]      = bus.busy;
    assign out_data_w[g]  = bus.out_data;
    assign enc_data_w[g]  = bus.enc_data;
    assign byte_cnt_w[g]  = bus.byte_cnt;

    // Source/sink driver and handshake monitor
    always begin : drv
      bit acc;
      bit ohs;
      bus.in_valid  = (src_q[g].size() > 0) && ($urandom_range(0, 99) < vprob);
      bus.in_data   = (src_q[g].size() > 0) ? src_q[g][0] : 8'($urandom);
      bus.out_ready = ($urandom_range(0, 99) < rprob);
      @(negedge clk);
      acc = !rst && bus.in_valid && bus.in_ready;
      ohs = !rst && bus.out_valid && bus.out_ready;
      if (acc) acc_q[g].push_back(bus.in_data);
      if (ohs) begin
        obs_d[g].push_back(bus.out_data);
        obs_l[g].push_back(bus.out_last);
      end
      if (!rst && bus.enc_clr)   clr_cnt[g]++;
      if (!rst && bus.enc_start) start_cnt[g]++;
      @(posedge clk);
      #1;
      if (acc && src_q[g].size() > 0) void'(src_q[g].pop_front());
    end
  end

  task automatic clear_obs();
    for (int d = 0; d < NDUT; d++) begin
      acc_q[d].delete();
      obs_d[d].delete();
      obs_l[d].delete();
      clr_cnt[d]   = 0;
      start_cnt[d] = 0;
    end
  endtask

  task automatic apply_reset(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) src_q[d].delete();
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_obs();
  endtask

  task automatic push_both(input byte_q_t b);
    for (int d = 0; d < NDUT; d++)
      for (int i = 0; i < b.size(); i++) src_q[d].push_back(b[i]);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (src_q[0].size() == 0 && src_q[1].size() == 0 && !busy_w[0] && !busy_w[1]
          && !in_valid_w[0] && !in_valid_w[1]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    byte_q_t b;
    logic [29:0] v;
    apply_reset(2);
    vprob = 100;
    rprob = 100;
    b = '{8'h11, 8'h22, 8'h33, 8'h44};
    push_both(b);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) src_q[d].delete();
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      v = {in_ready_w[d], enc_clr_w[d], enc_start_w[d], out_valid_w[d], out_last_w[d],
           busy_w[d], out_data_w[d], enc_data_w[d], byte_cnt_w[d]};
      tests++;
      if (v !== '0) begin
        fails++;
        $display("FAIL reset_outputs dut%0d: got %h want 0", d, v);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_obs();
    repeat (2) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      tests++;
      if ({busy_w[d], out_valid_w[d], enc_clr_w[d]} !== 3'b000) begin
        fails++;
        $display("FAIL reset_idle dut%0d: busy/valid/clr got %b want 000", d,
                 {busy_w[d], out_valid_w[d], enc_clr_w[d]});
      end
    end
  endtask

  task automatic test_stream();
    byte_q_t b, ed;
    bit_q_t  el;
    byte_t   lit [9];
    bit      ok;
    lit = '{8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};
    clear_obs();
    vprob = 100;
    rprob = 100;
    b = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    push_both(b);
    wait_done(500, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL stream_timeout: got busy after 500 cycles want idle"); end
    tests++;
    if (obs_d[0].size() != 9) begin
      fails++;
      $display("FAIL stream_len dut0: got %0d want 9", obs_d[0].size());
    end
    for (int i = 0; i < 9 && i < obs_d[0].size(); i++) begin
      tests++;
      if (obs_d[0][i] !== lit[i] || obs_l[0][i] !== (i == 8)) begin
        fails++;
        $display("FAIL stream_lit[%0d]: got %h/%b want %h/%b", i, obs_d[0][i], obs_l[0][i],
                 lit[i], (i == 8));
      end
    end
    for (int d = 0; d < NDUT; d++) begin
      build_exp(acc_q[d], tail_of(d), ed, el);
      tests++;
      if (obs_d[d].size() != ed.size() || ed.size() != 2 * FRAME_LEN + tail_of(d)) begin
        fails++;
        $display("FAIL stream_model_len dut%0d: got %0d want %0d", d, obs_d[d].size(), ed.size());
      end
      for (int i = 0; i < ed.size() && i < obs_d[d].size(); i++) begin
        tests++;
        if (obs_d[d][i] !== ed[i] || obs_l[d][i] !== el[i]) begin
          fails++;
          $display("FAIL stream_model dut%0d[%0d]: got %h/%b want %h/%b", d, i,
                   obs_d[d][i], obs_l[d][i], ed[i], el[i]);
        end
      end
      tests++;
      if (clr_cnt[d] != 1 || start_cnt[d] != FRAME_LEN + tail_of(d)) begin
        fails++;
        $display("FAIL stream_pulses dut%0d: clr/start got %0d/%0d want 1/%0d", d,
                 clr_cnt[d], start_cnt[d], FRAME_LEN + tail_of(d));
      end
    end
  endtask

  task automatic test_latency();
    byte_q_t b, ed;
    bit_q_t  el;
    int t_acc [NDUT];
    int t_st  [NDUT];
    int t_out [NDUT];
    bit ok;
    clear_obs();
    vprob = 100;
    rprob = 100;
    for (int d = 0; d < NDUT; d++) begin t_acc[d] = -1; t_st[d] = -1; t_out[d] = -1; end
    b = '{8'($urandom)};
    push_both(b);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        if (in_valid_w[d] && in_ready_w[d] && t_acc[d] < 0) t_acc[d] = cyc;
        if (enc_start_w[d] && t_st[d] < 0 && t_acc[d] >= 0) t_st[d] = cyc;
        if (out_valid_w[d] && t_out[d] < 0) t_out[d] = cyc;
      end
    end
    for (int d = 0; d < NDUT; d++) begin
      tests++;
      if (t_acc[d] < 0 || t_st[d] != t_acc[d] + 1) begin
        fails++;
        $display("FAIL latency_start dut%0d: got cycle %0d want %0d", d, t_st[d], t_acc[d] + 1);
      end
      tests++;
      if (t_acc[d] < 0 || t_out[d] != t_acc[d] + 2 + lat_of(d)) begin
        fails++;
        $display("FAIL latency_out dut%0d: got cycle %0d want %0d", d, t_out[d],
                 t_acc[d] + 2 + lat_of(d));
      end
    end
    b = '{8'($urandom), 8'($urandom), 8'($urandom)};
    push_both(b);
    wait_done(500, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL latency_timeout: got busy want idle"); end
    for (int d = 0; d < NDUT; d++) begin
      build_exp(acc_q[d], tail_of(d), ed, el);
      tests++;
      if (obs_d[d] != ed || obs_l[d] != el) begin
        fails++;
        $display("FAIL latency_stream dut%0d: got %0d bytes want %0d matching bytes", d,
                 obs_d[d].size(), ed.size());
      end
    end
  endtask

  task automatic test_backpressure();
    byte_q_t b, ed;
    bit_q_t  el;
    bit ok;
    clear_obs();
    vprob = 100;
    rprob = 0;
    b = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    push_both(b);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = out_valid_w[0] && out_valid_w[1];
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL stall_reach: got no out_valid want out_valid"); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        tests++;
        if (out_data_w[d] !== 8'hA5 || out_valid_w[d] !== 1'b1 || enc_start_w[d] !== 1'b0
            || in_ready_w[d] !== 1'b0 || out_last_w[d] !== 1'b0) begin
          fails++;
          $display("FAIL stall_hold dut%0d c%0d: data %h v%b st%b rdy%b last%b want A5 1 0 0 0",
                   d, c, out_data_w[d], out_valid_w[d], enc_start_w[d], in_ready_w[d],
                   out_last_w[d]);
        end
      end
    end
    rprob = 100;
    wait_done(500, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL stall_timeout: got busy want idle"); end
    for (int d = 0; d < NDUT; d++) begin
      tests++;
      if (obs_d[d].size() < 2 || obs_d[d][0] !== 8'hA5 || obs_d[d][1] !== 8'h5A) begin
        fails++;
        $display("FAIL stall_release dut%0d: got first bytes %h %h want A5 5A", d,
                 (obs_d[d].size() > 0) ? obs_d[d][0] : 8'hxx,
                 (obs_d[d].size() > 1) ? obs_d[d][1] : 8'hxx);
      end
      build_exp(acc_q[d], tail_of(d), ed, el);
      tests++;
      if (obs_d[d] != ed || obs_l[d] != el || start_cnt[d] != FRAME_LEN + tail_of(d)) begin
        fails++;
        $display("FAIL stall_stream dut%0d: got %0d bytes/%0d starts want %0d/%0d", d,
                 obs_d[d].size(), start_cnt[d], ed.size(), FRAME_LEN + tail_of(d));
      end
    end
  endtask

  task automatic test_reset_midframe();
    byte_q_t b, ed;
    bit_q_t  el;
    bit ok;
    clear_obs();
    vprob = 100;
    rprob = 100;
    b = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    push_both(b);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = (obs_d[0].size() >= 2);
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL midrst_reach: got %0d bytes want 2", obs_d[0].size()); end
    apply_reset(1);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      tests++;
      if (byte_cnt_w[d] !== 8'd0 || busy_w[d] !== 1'b0 || out_last_w[d] !== 1'b0) begin
        fails++;
        $display("FAIL midrst_state dut%0d: cnt %0d busy %b last %b want 0 0 0", d,
                 byte_cnt_w[d], busy_w[d], out_last_w[d]);
      end
    end
    b = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    push_both(b);
    wait_done(500, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL midrst_timeout: got busy want idle"); end
    for (int d = 0; d < NDUT; d++) begin
      build_exp(acc_q[d], tail_of(d), ed, el);
      tests++;
      if (obs_d[d] != ed || obs_l[d] != el || ed.size() != 2 * FRAME_LEN + tail_of(d)
          || clr_cnt[d] != 1) begin
        fails++;
        $display("FAIL midrst_stream dut%0d: got %0d bytes/%0d clr want %0d/1", d,
                 obs_d[d].size(), clr_cnt[d], 2 * FRAME_LEN + tail_of(d));
      end
    end
  endtask

  task automatic test_back_to_back();
    byte_q_t b, ed;
    bit_q_t  el;
    int stage [NDUT];
    int lasts [NDUT];
    bit ok;
    clear_obs();
    vprob = 100;
    rprob = 100;
    for (int d = 0; d < NDUT; d++) begin stage[d] = 0; lasts[d] = 0; end
    for (int i = 0; i < 2 * FRAME_LEN; i++) b.push_back(8'($urandom));
    push_both(b);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        if (stage[d] == 2) begin
          tests++;
          if (enc_clr_w[d] !== 1'b1 || busy_w[d] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_clr dut%0d: clr %b busy %b want 1 1", d, enc_clr_w[d], busy_w[d]);
          end
          stage[d] = 0;
        end else if (stage[d] == 1) begin
          tests++;
          if (byte_cnt_w[d] !== 8'd4 || busy_w[d] !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle dut%0d: cnt %0d busy %b want 4 0", d, byte_cnt_w[d], busy_w[d]);
          end
          stage[d] = (lasts[d] == 1) ? 2 : 0;
        end
        if (out_valid_w[d] && out_ready_w[d] && out_last_w[d]) begin
          lasts[d]++;
          stage[d] = 1;
        end
      end
    end
    wait_done(500, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL b2b_timeout: got busy want idle"); end
    for (int d = 0; d < NDUT; d++) begin
      build_exp(acc_q[d], tail_of(d), ed, el);
      tests++;
      if (obs_d[d] != ed || obs_l[d] != el || lasts[d] != 2 || clr_cnt[d] != 2) begin
        fails++;
        $display("FAIL b2b_stream dut%0d: got %0d bytes %0d lasts %0d clr want %0d 2 2", d,
                 obs_d[d].size(), lasts[d], clr_cnt[d], ed.size());
      end
    end
  endtask

  task automatic test_random();
    byte_q_t b, ed;
    bit_q_t  el;
    bit ok;
    for (int it = 0; it < 4; it++) begin
      clear_obs();
      vprob = $urandom_range(30, 100);
      rprob = $urandom_range(30, 100);
      b = {};
      for (int i = 0; i < 2 * FRAME_LEN; i++) b.push_back(8'($urandom));
      push_both(b);
      wait_done(3000, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL rand_timeout it%0d: got busy want idle", it); end
      for (int d = 0; d < NDUT; d++) begin
        build_exp(acc_q[d], tail_of(d), ed, el);
        tests++;
        if (obs_d[d] != ed || obs_l[d] != el || ed.size() != 2 * (2 * FRAME_LEN + tail_of(d))) begin
          fails++;
          $display("FAIL rand_stream it%0d dut%0d: got %0d bytes want %0d", it, d,
                   obs_d[d].size(), ed.size());
        end
        tests++;
        if (clr_cnt[d] != 2 || start_cnt[d] != 2 * (FRAME_LEN + tail_of(d))) begin
          fails++;
          $display("FAIL rand_pulses it%0d dut%0d: clr/start got %0d/%0d want 2/%0d", it, d,
                   clr_cnt[d], start_cnt[d], 2 * (FRAME_LEN + tail_of(d)));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_latency();
    test_backpressure();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
